// File: rtl/ecc_rd_check_pipe.sv
// SECDED receive check stage: decodes {ecc[6:0], data[31:0]}, registers the corrected word and flags
// behind a valid/ready handshake, and keeps saturating error counters, a first-error log and an irq.
module ecc_rd_check_pipe #(
  parameter int TAG_W      = 4,
  parameter int CNT_W      = 8,
  parameter int SBE_THRESH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [38:0]      in_word,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [6:0]       out_ecc,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_sbe,
  output logic             out_dbe,
  output logic [CNT_W-1:0] sbe_cnt,
  output logic [CNT_W-1:0] dbe_cnt,
  output logic             log_valid,
  output logic             log_dbe,
  output logic [TAG_W-1:0] log_tag,
  output logic [38:0]      log_word,
  input  logic             clr,
  output logic             irq
);

  localparam logic [1:0] LOG_EMPTY = 2'd0;
  localparam logic [1:0] LOG_SBE   = 2'd1;
  localparam logic [1:0] LOG_DBE   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(SBE_THRESH);

  // Hamming codeword with index = position-1; check bit k sits at position 2**k, overall parity at [38].
  logic [38:0] cw;
  logic [5:0]  syn;
  logic [6:0]  chk;
  logic [38:0] err_mask;
  logic [38:0] cor;
  logic        dec_sbe;
  logic        dec_dbe;
  logic [31:0] dec_data;
  logic [6:0]  dec_ecc;

  assign cw = {in_word[38], in_word[31:26], in_word[37], in_word[25:11], in_word[36],
               in_word[10:4], in_word[35], in_word[3:1], in_word[34], in_word[0], in_word[33:32]};

  for (genvar gi = 0; gi < 6; gi++) begin : g_syn
    logic [37:0] sel;
    for (genvar gj = 0; gj < 38; gj++) begin : g_sel
      if ((((gj + 1) >> gi) % 2) == 1) begin : g_on
        assign sel[gj] = cw[gj];
      end else begin : g_off
        assign sel[gj] = 1'b0;
      end
    end
    assign syn[gi] = ^sel;
  end

  assign chk     = {^cw, syn};
  assign dec_sbe = (chk != 7'd0) && chk[6];
  assign dec_dbe = (chk != 7'd0) && !chk[6];

  for (genvar gi = 0; gi < 39; gi++) begin : g_mask
    assign err_mask[gi] = ({1'b0, syn} == 7'(gi + 1));
  end

  assign cor      = dec_sbe ? (cw ^ err_mask) : cw;
  assign dec_data = {cor[37:32], cor[30:16], cor[14:8], cor[6:4], cor[2]};
  assign dec_ecc  = {cor[38] ^ (chk == 7'b1000000), cor[31], cor[15], cor[7], cor[3], cor[1:0]};

  logic             out_valid_q;
  logic [31:0]      out_data_q;
  logic [6:0]       out_ecc_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_sbe_q, out_dbe_q;
  logic [CNT_W-1:0] sbe_cnt_q, sbe_cnt_d, dbe_cnt_q, dbe_cnt_d;
  logic [1:0]       log_state_q, log_state_d;
  logic [TAG_W-1:0] log_tag_q, log_tag_d;
  logic [38:0]      log_word_q, log_word_d;
  logic             irq_q, irq_d;
  logic             accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ecc_q   <= '0;
      out_tag_q   <= '0;
      out_sbe_q   <= 1'b0;
      out_dbe_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= dec_data;
      out_ecc_q   <= dec_ecc;
      out_tag_q   <= in_tag;
      out_sbe_q   <= dec_sbe;
      out_dbe_q   <= dec_dbe;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // clr overrides any statistics update from a coincident accept.
  always_comb begin
    sbe_cnt_d   = sbe_cnt_q;
    dbe_cnt_d   = dbe_cnt_q;
    log_state_d = log_state_q;
    log_tag_d   = log_tag_q;
    log_word_d  = log_word_q;
    irq_d       = irq_q;
    if (clr) begin
      sbe_cnt_d   = '0;
      dbe_cnt_d   = '0;
      log_state_d = LOG_EMPTY;
      irq_d       = 1'b0;
    end else if (accept) begin
      if (dec_sbe && sbe_cnt_q != CNT_MAX) sbe_cnt_d = sbe_cnt_q + 1'b1;
      if (dec_dbe && dbe_cnt_q != CNT_MAX) dbe_cnt_d = dbe_cnt_q + 1'b1;
      if (dec_dbe && log_state_q != LOG_DBE) begin
        log_state_d = LOG_DBE;
        log_tag_d   = in_tag;
        log_word_d  = in_word;
      end else if (dec_sbe && log_state_q == LOG_EMPTY) begin
        log_state_d = LOG_SBE;
        log_tag_d   = in_tag;
        log_word_d  = in_word;
      end
      if (dec_dbe || sbe_cnt_d >= THRESH) irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sbe_cnt_q   <= '0;
      dbe_cnt_q   <= '0;
      log_state_q <= LOG_EMPTY;
      log_tag_q   <= '0;
      log_word_q  <= '0;
      irq_q       <= 1'b0;
    end else begin
      sbe_cnt_q   <= sbe_cnt_d;
      dbe_cnt_q   <= dbe_cnt_d;
      log_state_q <= log_state_d;
      log_tag_q   <= log_tag_d;
      log_word_q  <= log_word_d;
      irq_q       <= irq_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ecc   = out_ecc_q;
  assign out_tag   = out_tag_q;
  assign out_sbe   = out_sbe_q;
  assign out_dbe   = out_dbe_q;
  assign sbe_cnt   = sbe_cnt_q;
  assign dbe_cnt   = dbe_cnt_q;
  assign log_valid = (log_state_q != LOG_EMPTY);
  assign log_dbe   = (log_state_q == LOG_DBE);
  assign log_tag   = log_tag_q;
  assign log_word  = log_word_q;
  assign irq       = irq_q;

endmodule
